universal_shift_reg: RTL
========================

Name: universal_shift_reg

Overview:
- Parametrised universal register built for the PIPO register family.
- Combines parallel load with shift right/left and rotate right/left. This gives PIPO, SIPO, PISO and SISO operation from one block.
- Tracks serial shifts since the last load or clear. Flags each completed serial word so a SIPO receiver or PISO transmitter needs no external counter.
- Sits between the data path and serial link logic. Drop-in replacement for banks of single-bit flip-flop registers.

Parameters:
- WIDTH, 8, register width in bits (>= 1).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- en  input  1  operation enable; 0 = hold everything.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- sin_msb  input  1  serial input entering bit WIDTH-1 on shift right.
- sin_lsb  input  1  serial input entering bit 0 on shift left.
- q  output  WIDTH  register contents.
- sout_lsb  output  1  q[0], combinational from q.
- sout_msb  output  1  q[WIDTH-1], combinational from q.
- bit_cnt  output  CW = $clog2(WIDTH+1)  serial shifts since last load/clear/wrap, range 0..WIDTH-1.
- word_valid  output  1  registered one-cycle pulse: a full word of WIDTH shifts has completed.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - q = RESET_VALUE, bit_cnt = 0, word_valid = 0.
  - While reset is high, clock edges have no effect.
  - First active edge is the first rising clk after reset deasserts.
- All state changes on rising clk only. Latency 1 cycle from inputs to q/bit_cnt/word_valid.
- en = 0: q and bit_cnt hold; word_valid = 0.
- en = 1, mode encoding:
  - 000 hold: q and bit_cnt unchanged.
  - 001 shift right: q <= {sin_msb, q[WIDTH-1:1]}; counts as shift.
  - 010 shift left: q <= {q[WIDTH-2:0], sin_lsb}; counts as shift.
  - 011 rotate right: q <= {q[0], q[WIDTH-1:1]}; bit_cnt unchanged.
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; bit_cnt unchanged.
  - 101 parallel load: q <= d; bit_cnt <= 0.
  - 110 clear: q <= 0 (not RESET_VALUE); bit_cnt <= 0.
  - 111 reserved: behaves as hold.
- Shift counting:
  - Each shift op (001 or 010) with bit_cnt < WIDTH-1 increments bit_cnt.
  - A shift op with bit_cnt == WIDTH-1 sets bit_cnt <= 0 and word_valid <= 1 on the same edge.
  - word_valid is 0 on every other edge, including the edge after a pulse unless that edge also completes a word. Back-to-back words therefore give one pulse every WIDTH shifts.
  - Shift direction is irrelevant to counting; mixed left/right shifts accumulate in the same count.
  - Load or clear on the edge that would complete a word takes priority: bit_cnt = 0, word_valid = 0.
- WIDTH = 1:
  - Shift right loads sin_msb; shift left loads sin_lsb.
  - Rotates are no-ops.
  - Every shift pulses word_valid; bit_cnt stays 0.
- Outputs contain no combinational paths from inputs. sout_* depend only on q.

Test Plan:
- WIDTH=8: assert reset with clk stopped -> q=0x00, bit_cnt=0, word_valid=0 immediately. Deassert, then en=0 for 3 edges with d=0xFF, mode=101 -> q stays 0x00.
- Load d=0xA5 (mode 101). Then 8 edges of shift right with sin_msb=0 -> sout_lsb sequence 1,0,1,0,0,1,0,1. bit_cnt counts 1..7, then 0. word_valid high exactly one cycle after the 8th edge. Final q=0x00.
- SIPO: 8 shift-left edges with sin_lsb sequence 1,1,0,0,1,0,1,0 -> q=0xCA. word_valid pulses once. Continue 16 more shifts -> exactly two further pulses, 8 edges apart.
- Load 0x81, rotate left once -> q=0x03. Rotate right twice -> q=0xC0. bit_cnt stays 0 and word_valid stays 0 throughout.
- Shift 7 times (bit_cnt=7), then mode 101 with d=0x3C -> q=0x3C, bit_cnt=0, no word_valid pulse. Repeat the setup, then mode 110 -> q=0x00, bit_cnt=0.
- Shift 4 times, assert reset between clock edges -> q=RESET_VALUE and bit_cnt=0 without waiting for clk. Mode 111 -> hold. Repeat the load/shift cases with WIDTH=1 and WIDTH=13 -> every shift pulses word_valid (WIDTH=1); pulse after every 13 shifts (WIDTH=13).

Source files
------------

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal PIPO/SIPO/PISO/SISO register with serial word counter
module universal_shift_reg #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin_msb,
  input  logic                         sin_lsb,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_lsb,
  output logic                         sout_msb,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         word_valid
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_word_valid;

  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_rol;
  logic             w_is_shift;
  logic             w_is_reset_cnt;
  logic             w_wrap;

  // A one-bit register has no neighbours: shifts take the serial input, rotates keep the bit.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shr = sin_msb;
      assign w_shl = sin_lsb;
      assign w_ror = r_q;
      assign w_rol = r_q;
    end else begin : g_wn
      assign w_shr = {sin_msb, r_q[WIDTH-1:1]};
      assign w_shl = {r_q[WIDTH-2:0], sin_lsb};
      assign w_ror = {r_q[0], r_q[WIDTH-1:1]};
      assign w_rol = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    end
  endgenerate

  // Only true shifts advance the word counter; rotates leave it alone.
  assign w_is_shift     = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
  assign w_is_reset_cnt = en && ((mode == MODE_LOAD) || (mode == MODE_CLR));
  assign w_wrap         = w_is_shift && (r_bit_cnt == LAST_CNT);

  // Register contents, shift counter and word-complete pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q          <= RESET_VALUE;
      r_bit_cnt    <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= w_wrap;
      if (en) begin
        case (mode)
          MODE_SHR:  r_q <= w_shr;
          MODE_SHL:  r_q <= w_shl;
          MODE_ROR:  r_q <= w_ror;
          MODE_ROL:  r_q <= w_rol;
          MODE_LOAD: r_q <= d;
          MODE_CLR:  r_q <= '0;
          default:   r_q <= r_q;
        endcase
      end
      if (w_is_shift) begin
        r_bit_cnt <= w_wrap ? '0 : r_bit_cnt + CW'(1);
      end else if (w_is_reset_cnt) begin
        r_bit_cnt <= '0;
      end
    end
  end

  assign q          = r_q;
  assign sout_lsb   = r_q[0];
  assign sout_msb   = r_q[WIDTH-1];
  assign bit_cnt    = r_bit_cnt;
  assign word_valid = r_word_valid;

endmodule
